rob_alloc: RTL and testbench

- In-order reorder-buffer entry allocator and commit sequencer.
- Hands each decoded instruction a ROB id (dec_rob_id) in the same cycle rename uses it.
- Tracks per-entry completion from writeback and retires entries in program order via commit_e_/com_rob_id. These same signals invalidate rename map entries.
- Owns head/tail pointers, occupancy, full/empty, and flush recovery.

---
 rtl/rob_alloc.sv | 101 ++++++++++
 tb/tb_rob_alloc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc.sv
// In-order ROB allocator/commit sequencer: ids issued at tail, retired at head in program order.
// Writeback-to-commit latency 1 cycle (0 with ROB_WB_COMMIT_BYPASS_EN); decode stalls on rob_full.
module rob_alloc #(
  parameter int ROB_DEPTH = 4,
  localparam int ROB = $clog2(ROB_DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush_,
  input  logic           dec_e_,
  input  logic           dec_invalid,
  output logic [ROB-1:0] dec_rob_id,
  output logic           rob_full,
  output logic           rob_empty,
  output logic [ROB:0]   rob_count,
  input  logic           wb_e_,
  input  logic [ROB-1:0] wb_rob_id,
  output logic           commit_e_,
  output logic [ROB-1:0] com_rob_id,
  output logic           com_exc
);

  logic [ROB-1:0]       head_q, head_d, tail_q, tail_d;
  logic [ROB:0]         count_q, count_d;
  logic [ROB_DEPTH-1:0] valid_q, valid_d, done_q, done_d, exc_q, exc_d;
  logic                 alloc, wb_hit, head_ready, commit;

  always_comb begin
    rob_full  = (count_q == (ROB+1)'(ROB_DEPTH));
    rob_empty = (count_q == '0);
    alloc     = !dec_e_ && !rob_full;
    wb_hit    = !wb_e_ && valid_q[wb_rob_id];
`ifdef ROB_WB_COMMIT_BYPASS_EN
    head_ready = valid_q[head_q] && (done_q[head_q] || (!wb_e_ && (wb_rob_id == head_q)));
`else
    head_ready = valid_q[head_q] && done_q[head_q];
`endif
    commit = head_ready && flush_;
  end

  always_comb begin
    dec_rob_id = tail_q;
    rob_count  = count_q;
    commit_e_  = !commit;
    com_rob_id = head_q;
    com_exc    = commit && exc_q[head_q];
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    exc_d   = exc_q;
    if (!flush_) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      done_d  = '0;
      exc_d   = '0;
    end else begin
      if (wb_hit) done_d[wb_rob_id] = 1'b1;
      if (alloc) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = dec_invalid;
        exc_d[tail_q]   = dec_invalid;
        tail_d          = tail_q + ROB'(1);
      end
      // Retirement clears last so a same-cycle writeback to head cannot leave a stale done bit.
      if (commit) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        exc_d[head_q]   = 1'b0;
        head_d          = head_q + ROB'(1);
      end
      if (alloc && !commit)      count_d = count_q + (ROB+1)'(1);
      else if (commit && !alloc) count_d = count_q - (ROB+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
    end
  end

endmodule

// File: tb/tb_rob_alloc.sv
// Directed bench for rob_alloc with ROB_DEPTH=4; inputs change 1 unit after posedge, outputs sampled 1 unit later.
module tb_rob_alloc;

  localparam int ROB_DEPTH = 4;
  localparam int ROB = 2;

  logic           clk = 1'b0;
  logic           reset, flush_, dec_e_, dec_invalid, wb_e_;
  logic [ROB-1:0] wb_rob_id, dec_rob_id, com_rob_id;
  logic           rob_full, rob_empty, commit_e_, com_exc;
  logic [ROB:0]   rob_count;

  int n_checks = 0;
  int n_errors = 0;

  rob_alloc #(.ROB_DEPTH(ROB_DEPTH)) dut (
    .clk(clk), .reset(reset), .flush_(flush_),
    .dec_e_(dec_e_), .dec_invalid(dec_invalid), .dec_rob_id(dec_rob_id),
    .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count),
    .wb_e_(wb_e_), .wb_rob_id(wb_rob_id),
    .commit_e_(commit_e_), .com_rob_id(com_rob_id), .com_exc(com_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush_ = 1'b1; dec_e_ = 1'b1; dec_invalid = 1'b0; wb_e_ = 1'b1; wb_rob_id = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
  endtask

  task automatic alloc(input logic inv);
    idle();
    dec_e_ = 1'b0; dec_invalid = inv;
    tick();
    idle();
    settle();
  endtask

  task automatic wb(input logic [ROB-1:0] id);
    idle();
    wb_e_ = 1'b0; wb_rob_id = id;
    tick();
    idle();
    settle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick();
    do_reset();
    check("rst_dec_rob_id", dec_rob_id, 0);
    check("rst_full",       rob_full,   0);
    check("rst_empty",      rob_empty,  1);
    check("rst_count",      rob_count,  0);
    check("rst_commit_e_",  commit_e_,  1);
    check("rst_com_rob_id", com_rob_id, 0);
    check("rst_com_exc",    com_exc,    0);

    // Fill: ids handed out in order, then a request while full is ignored.
    for (int i = 0; i < 4; i++) begin
      idle(); dec_e_ = 1'b0; settle();
      check($sformatf("fill_id%0d", i), dec_rob_id, i);
      check($sformatf("fill_notfull%0d", i), rob_full, 0);
      tick();
    end
    idle(); settle();
    check("full_flag",   rob_full,  1);
    check("full_count",  rob_count, 4);
    check("full_empty",  rob_empty, 0);
    check("full_nocom",  commit_e_, 1);
    alloc(1'b0);
    check("full_ign_tail",  dec_rob_id, 0);
    check("full_ign_count", rob_count,  4);

`ifndef ROB_WB_COMMIT_BYPASS_EN
    // Out-of-order writeback; retirement waits for head.
    wb(2);
    check("wb2_nocom", commit_e_, 1);
    idle(); wb_e_ = 1'b0; wb_rob_id = 0; settle();
    check("wb0_same_cycle_nocom", commit_e_, 1);
    tick(); idle(); settle();
    check("com0_e",  commit_e_,  0);
    check("com0_id", com_rob_id, 0);
    check("com0_exc", com_exc,   0);
    check("com0_cnt", rob_count, 4);
    tick();
    check("head1_wait", commit_e_,  1);
    check("head1_id",   com_rob_id, 1);
    check("cnt3",       rob_count,  3);
    wb(1);
    check("com1_e",  commit_e_,  0);
    check("com1_id", com_rob_id, 1);
    tick();
    check("com2_e",  commit_e_,  0);
    check("com2_id", com_rob_id, 2);
    check("cnt2",    rob_count,  2);
    tick();
    check("head3_wait", commit_e_,  1);
    check("head3_id",   com_rob_id, 3);
    check("cnt1",       rob_count,  1);

    // Full with head done: alloc in the commit cycle is rejected, then wraps to id 0.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(1'b0);
    wb(0);
    idle(); dec_e_ = 1'b0; settle();
    check("rej_full",   rob_full,   1);
    check("rej_commit", commit_e_,  0);
    tick(); idle(); settle();
    check("rej_notfull", rob_full,   0);
    check("rej_cnt",     rob_count,  3);
    check("rej_tail",    dec_rob_id, 0);
    check("rej_head",    com_rob_id, 1);
    alloc(1'b0);
    check("wrap_cnt",  rob_count,  4);
    check("wrap_full", rob_full,   1);
    check("wrap_tail", dec_rob_id, 1);

    // Invalid instruction retires next cycle with the exception flag.
    do_reset();
    alloc(1'b1);
    check("exc_commit_e", commit_e_,  0);
    check("exc_id",       com_rob_id, 0);
    check("exc_flag",     com_exc,    1);
    check("exc_cnt",      rob_count,  1);
    tick();
    check("exc_empty",    rob_empty,  1);
    check("exc_after_e",  commit_e_,  1);
    check("exc_after_fl", com_exc,    0);
    check("exc_head",     com_rob_id, 1);

    // Flush with alloc and writeback in the same cycle.
    do_reset();
    for (int i = 0; i < 3; i++) alloc(1'b0);
    wb(0);
    check("prefl_commit", commit_e_, 0);
    flush_ = 1'b0; dec_e_ = 1'b0; wb_e_ = 1'b0; wb_rob_id = 1; settle();
    check("fl_forced_e", commit_e_, 1);
    check("fl_exc",      com_exc,   0);
    tick(); idle(); settle();
    check("fl_cnt",   rob_count,  0);
    check("fl_empty", rob_empty,  1);
    check("fl_tail",  dec_rob_id, 0);
    check("fl_head",  com_rob_id, 0);
    check("fl_nocom", commit_e_,  1);
    wb(0);
    alloc(1'b0);
    check("wb_invalid_ignored", commit_e_, 1);
`else
    // Writeback to head commits in the same cycle.
    do_reset();
    alloc(1'b0);
    alloc(1'b0);
    wb_e_ = 1'b0; wb_rob_id = 0; settle();
    check("byp_commit_e", commit_e_,  0);
    check("byp_id",       com_rob_id, 0);
    tick(); idle(); settle();
    check("byp_head",  com_rob_id, 1);
    check("byp_cnt",   rob_count,  1);
    check("byp_after", commit_e_,  1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
